cbc_decrypt_seq: RTL and testbench
==================================

Name: cbc_decrypt_seq

Overview:
Clocked CBC decryption core. It is the inverse of the n_block_cbc encrypt path.
- Accepts one ciphertext message of NUM_BLOCKS 32-bit blocks plus a 32-bit key.
- Recovers plaintext at one block per cycle.
- Presents the result on an HLS-style block-level handshake (ap_start/ap_done/ap_idle/ap_ready), so it drops into the same integration flow as the encrypt side.

Parameters:
NUM_BLOCKS, 2, number of 32-bit blocks per message (legal range 1..16).
BLOCK_W, 32, block width in bits; fixed, taken from the package, not overridable.

Ports:
ap_clk  in  1  clock; all state changes on the rising edge.
ap_rst_n  in  1  synchronous, active-low reset.
ap_start  in  1  request to start; sampled only in IDLE.
ap_done  out  1  one-cycle pulse; ap_return valid from this cycle on.
ap_idle  out  1  high while in IDLE.
ap_ready  out  1  one-cycle pulse, coincident with ap_done.
message  in  NUM_BLOCKS*32  ciphertext; block 0 = most-significant 32 bits.
key  in  32  cipher key.
ap_return  out  NUM_BLOCKS*32  plaintext; same block ordering as message.

Behaviour:
- Cipher definition (must match the encrypt side):
  - C0 = P0 ^ K; Ci = Pi ^ C(i-1) for i ≥ 1.
  - Decrypt: P0 = C0 ^ K; Pi = Ci ^ C(i-1).
  - Block j occupies bits [NUM_BLOCKS*32-1-32*j -: 32].
- Reset (ap_rst_n = 0 at a clock edge):
  - State goes to IDLE; ap_return = 0, ap_done = 0, ap_ready = 0, ap_idle = 1 on the following cycle.
  - Internal message/key/plaintext registers and the block index are cleared.
  - Reset wins over every other event.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ap_idle = 1. If ap_start = 1, latch message and key into internal registers, clear the index, go to RUN. Otherwise stay in IDLE.
  - RUN: ap_idle = 0. Each cycle, compute plaintext block idx from the latched ciphertext:
    - idx = 0 uses the latched key.
    - idx > 0 uses latched ciphertext block idx-1.
    - Write the result into the plaintext register at block idx, then idx++.
    - When idx = NUM_BLOCKS-1 is processed, go to DONE.
  - DONE: ap_done = 1 and ap_ready = 1 for exactly this cycle. ap_return is driven from the plaintext register. Next state is IDLE unconditionally.
- Latency: start accepted at edge T → ap_done high in cycle T+NUM_BLOCKS+1 (NUM_BLOCKS = 2: 3 cycles).
- ap_return holds its value from DONE until the next DONE or reset. It is not updated mid-run; the plaintext register is separate from the output register.
- Inputs message/key may change freely after acceptance and have no effect until the next acceptance.
- ap_start held high continuously: back-to-back runs with one IDLE cycle between DONE and the next acceptance. Throughput is one message per NUM_BLOCKS+2 cycles.
- ap_start pulses outside IDLE are ignored and not queued.
- Reset mid-RUN: abort, no ap_done, ap_return = 0.
- NUM_BLOCKS = 1: RUN lasts one cycle; only the key term is used.
- Index counter width: $clog2(NUM_BLOCKS) bits, minimum 1. It never wraps past NUM_BLOCKS-1.

Decomposition:
- Package cbc_pkg:
  - BLOCK_W = 32.
  - block_t typedef (logic [31:0]).
  - state enum cbc_state_e {IDLE, RUN, DONE}.
  - Function block_sel(msg, j) returning block j.
- Sub-module cbc_block_dec: combinational, 2 inputs (cipher block, chain value = key or previous cipher block), 1 output (plaintext block). Reused by a future pipelined variant.
- The top module holds the FSM, index counter and registers.

Test Plan:
- Reset, then decrypt message=64'h0, key=32'h0 → ap_return = 64'h0; ap_done exactly 3 cycles after acceptance; ap_idle low during RUN/DONE.
- message=64'h00b0d0f060b0a0f0, key=32'h10101010 → ap_return = 64'h10a0c0e060007000; ap_ready coincident with ap_done.
- message=64'h000010f0100063f0, key=32'h10101010 → 64'h101000e010007300. Change message/key the cycle after acceptance → result unchanged.
- message=64'h1111111100000000, key=32'h0 → 64'h1111111111111111. Hold ap_start high → second run's ap_done 4 cycles after the first's, ap_return stable in between.
- Start a run with ap_return = 64'h10a0c0e060007000 held from the prior run, assert ap_rst_n=0 during RUN → no ap_done, ap_return = 0, ap_idle = 1 next cycle; fresh start then completes normally.
- NUM_BLOCKS=1 build: message=32'h00b0d0f0, key=32'h10101010 → 32'h10a0c0e0, ap_done 2 cycles after acceptance.

Source files
------------

// File: rtl/cbc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbc_pkg
// Description : Shared types, constants and block selection for the CBC cores.
// Revision    : 1.0
// ============================================================================
package cbc_pkg;

    localparam int BLOCK_W    = 32;
    localparam int MAX_BLOCKS = 16;
    localparam int MAX_MSG_W  = MAX_BLOCKS * BLOCK_W;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cbc_state_e;

    // msg is left-aligned in a MAX_MSG_W vector so block 0 is always the top word.
    function automatic block_t block_sel(input logic [MAX_MSG_W-1:0] msg, input int j);
        return msg[MAX_MSG_W-1-BLOCK_W*j -: BLOCK_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbc_block_dec.sv
`default_nettype none
// ============================================================================
// Module      : cbc_block_dec
// Description : Single-block CBC decrypt: plaintext = cipher XOR chain value.
// Revision    : 1.0
// ============================================================================
module cbc_block_dec
    import cbc_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_cipher,
    input  logic [BLOCK_W-1:0] i_chain,
    output logic [BLOCK_W-1:0] o_plain
);

    assign o_plain = i_cipher ^ i_chain;

endmodule
`default_nettype wire

// File: rtl/cbc_decrypt_seq.sv
`default_nettype none
// ============================================================================
// Module      : cbc_decrypt_seq
// Description : Sequential CBC decrypt, one block per cycle, ap_* handshake.
// Revision    : 1.0
// ============================================================================
module cbc_decrypt_seq
    import cbc_pkg::*;
#(
    parameter int NUM_BLOCKS = 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_idle,
    output logic                          ap_ready,
    input  logic [NUM_BLOCKS*BLOCK_W-1:0] message,
    input  logic [BLOCK_W-1:0]            key,
    output logic [NUM_BLOCKS*BLOCK_W-1:0] ap_return
);

    localparam int c_msg_w = NUM_BLOCKS * BLOCK_W;
    localparam int c_idx_w = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_BLOCKS - 1);

    cbc_state_e           r_state;
    cbc_state_e           w_state_next;
    logic [c_msg_w-1:0]   r_msg;
    logic [c_msg_w-1:0]   r_plain;
    logic [c_msg_w-1:0]   r_return;
    logic [c_msg_w-1:0]   w_plain_next;
    block_t               r_key;
    block_t               w_cipher;
    block_t               w_chain;
    block_t               w_plain_blk;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_idx_w-1:0]   w_prev_idx;
    logic [MAX_MSG_W-1:0] w_msg_wide;
    logic                 w_last;

    always_comb begin
        w_msg_wide = '0;
        w_msg_wide[MAX_MSG_W-1 -: c_msg_w] = r_msg;
    end

    assign w_last     = (r_idx == c_last_idx);
    assign w_prev_idx = (r_idx == '0) ? '0 : r_idx - 1'b1;
    assign w_cipher   = block_sel(w_msg_wide, int'(r_idx));
    // The first block chains from the key, every later one from the previous ciphertext.
    assign w_chain    = (r_idx == '0) ? r_key : block_sel(w_msg_wide, int'(w_prev_idx));

    cbc_block_dec u_dec (
        .i_cipher (w_cipher),
        .i_chain  (w_chain),
        .o_plain  (w_plain_blk)
    );

    generate
        for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_blk
            assign w_plain_next[c_msg_w-1-BLOCK_W*j -: BLOCK_W] =
                (r_idx == c_idx_w'(j)) ? w_plain_blk : r_plain[c_msg_w-1-BLOCK_W*j -: BLOCK_W];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        ap_idle      = 1'b0;
        ap_done      = 1'b0;
        ap_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                ap_done      = 1'b1;
                ap_ready     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state  <= IDLE;
            r_msg    <= '0;
            r_key    <= '0;
            r_plain  <= '0;
            r_return <= '0;
            r_idx    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (ap_start) begin
                        r_msg <= message;
                        r_key <= key;
                        r_idx <= '0;
                    end
                end
                RUN: begin
                    r_plain <= w_plain_next;
                    // Output is loaded with the final block merged in, so it is valid in DONE.
                    if (w_last) begin
                        r_return <= w_plain_next;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_return = r_return;

endmodule
`default_nettype wire

// File: tb/tb_cbc_decrypt_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbc_decrypt_seq
// Description : Directed self-checking bench for cbc_decrypt_seq (N=2 and N=1).
// Revision    : 1.0
// ============================================================================
module tb_cbc_decrypt_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] message;
    logic [31:0] key;
    logic [63:0] ap_return;

    logic        start1;
    logic        done1;
    logic        idle1;
    logic        ready1;
    logic [31:0] message1;
    logic [31:0] key1;
    logic [31:0] ret1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ap_clk = ~ap_clk;

    cbc_decrypt_seq #(.NUM_BLOCKS(2)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .message   (message),
        .key       (key),
        .ap_return (ap_return)
    );

    cbc_decrypt_seq #(.NUM_BLOCKS(1)) dut1 (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ap_start  (start1),
        .ap_done   (done1),
        .ap_idle   (idle1),
        .ap_ready  (ready1),
        .message   (message1),
        .key       (key1),
        .ap_return (ret1)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ap_done was observed.
    task automatic do_run(input string tag, input logic [63:0] m, input logic [31:0] k,
                          input logic [63:0] exp, input bit scramble);
        int cyc = 1;
        bit idle_bad = 1'b0;
        message  = m;
        key      = k;
        ap_start = 1'b1;
        check_val({tag, "_idle_at_accept"}, 64'(ap_idle), 64'd1);
        @(negedge ap_clk);
        ap_start = 1'b0;
        if (scramble) begin
            message = ~m;
            key     = ~k;
        end
        while (!ap_done && cyc < 20) begin
            if (ap_idle) idle_bad = 1'b1;
            @(negedge ap_clk);
            cyc++;
        end
        if (ap_idle) idle_bad = 1'b1;
        check_val({tag, "_latency"}, 64'(cyc), 64'd3);
        check_val({tag, "_ready"}, 64'(ap_ready), 64'd1);
        check_val({tag, "_return"}, ap_return, exp);
        check_val({tag, "_idle_low"}, 64'(idle_bad), 64'd0);
        @(negedge ap_clk);
        check_val({tag, "_done_pulse"}, 64'(ap_done), 64'd0);
        check_val({tag, "_hold"}, ap_return, exp);
    endtask

    initial begin
        int gap;
        bit stable;
        int cyc;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        message  = '0;
        key      = '0;
        start1   = 1'b0;
        message1 = '0;
        key1     = '0;
        repeat (3) @(negedge ap_clk);
        check_val("rst_idle", 64'(ap_idle), 64'd1);
        check_val("rst_done", 64'(ap_done), 64'd0);
        check_val("rst_ready", 64'(ap_ready), 64'd0);
        check_val("rst_return", ap_return, 64'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        do_run("zero", 64'h0, 32'h0, 64'h0, 1'b0);
        do_run("vec_a", 64'h00b0d0f060b0a0f0, 32'h10101010, 64'h10a0c0e060007000, 1'b0);
        do_run("vec_b", 64'h000010f0100063f0, 32'h10101010, 64'h101000e010007300, 1'b1);

        // Back-to-back with ap_start held high.
        message  = 64'h1111111100000000;
        key      = 32'h0;
        ap_start = 1'b1;
        cyc = 0;
        while (!ap_done && cyc < 20) begin
            @(negedge ap_clk);
            cyc++;
        end
        check_val("b2b_first_latency", 64'(cyc), 64'd3);
        check_val("b2b_first_return", ap_return, 64'h1111111111111111);
        gap = 0;
        stable = 1'b1;
        do begin
            @(negedge ap_clk);
            gap++;
            if (!ap_done && ap_return !== 64'h1111111111111111) stable = 1'b0;
        end while (!ap_done && gap < 20);
        ap_start = 1'b0;
        check_val("b2b_gap", 64'(gap), 64'd4);
        check_val("b2b_stable", 64'(stable), 64'd1);
        check_val("b2b_second_return", ap_return, 64'h1111111111111111);
        @(negedge ap_clk);

        // Reset in the middle of a run.
        do_run("pre_rst", 64'h00b0d0f060b0a0f0, 32'h10101010, 64'h10a0c0e060007000, 1'b0);
        message  = 64'h000010f0100063f0;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        check_val("mid_run_no_done", 64'(ap_done), 64'd0);
        check_val("mid_run_not_idle", 64'(ap_idle), 64'd0);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        check_val("abort_done", 64'(ap_done), 64'd0);
        check_val("abort_return", ap_return, 64'd0);
        check_val("abort_idle", 64'(ap_idle), 64'd1);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check_val("abort_stays_quiet", 64'(ap_done), 64'd0);
        do_run("post_rst", 64'h000010f0100063f0, 32'h10101010, 64'h101000e010007300, 1'b0);

        // Single-block build.
        message1 = 32'h00b0d0f0;
        key1     = 32'h10101010;
        start1   = 1'b1;
        check_val("n1_idle_at_accept", 64'(idle1), 64'd1);
        @(negedge ap_clk);
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 20) begin
            @(negedge ap_clk);
            cyc++;
        end
        check_val("n1_latency", 64'(cyc), 64'd2);
        check_val("n1_ready", 64'(ready1), 64'd1);
        check_val("n1_return", 64'(ret1), 64'h10a0c0e0);
        @(negedge ap_clk);
        check_val("n1_done_pulse", 64'(done1), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
